// File: rtl/neuron_out_queue.sv
// neuron_out_queue: byte FIFO between the neuron emitters and the host pins, popped by a synchronized host ack edge.
module neuron_out_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          flush,
  input  logic          emit_valid,
  input  logic [7:0]    emit_data,
  input  logic          host_ack,
  output logic          have_out,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic [AW:0]   occupancy,
  output logic [7:0]    drop_count
);
  localparam logic [AW:0] full_cnt = DEPTH[AW:0];
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic ack_s1, ack_s2, ack_s3;
  logic [2:0] live;
  logic full, empty, ack_rise, push, pop;
  // live marks when ack_s3 holds a real pin sample, so an ack held high through reset is not seen as an edge
  assign full = count == full_cnt;
  assign empty = count == '0;
  assign ack_rise = ack_s2 & ~ack_s3 & live[2];
  assign push = ena & emit_valid & ~full;
  assign pop = ena & ack_rise & ~empty;
  assign have_out = full;
  assign out_valid = ~empty;
  assign out_data = empty ? 8'h00 : mem[rd_ptr];
  assign occupancy = count;
  always_ff @(posedge clk)
    if (push & ~flush) mem[wr_ptr] <= emit_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      drop_count <= '0;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_s3 <= 1'b0;
      live <= '0;
    end else begin
      ack_s1 <= host_ack;
      ack_s2 <= ack_s1;
      ack_s3 <= ack_s2;
      live <= {live[1:0], 1'b1};
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (ena & emit_valid & full & (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_neuron_out_queue.sv
// tb_neuron_out_queue: table vectors, directed corner sequences and random traffic checked against a queue model.
module tb_neuron_out_queue;
  logic clk = 1'b0;
  logic rst_n, ena, flush, emit_valid, host_ack;
  logic [7:0] emit_data;
  logic have_out, out_valid;
  logic [7:0] out_data, drop_count;
  logic [2:0] occupancy;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  bit hist[$];
  int n;
  int mdrop;

  neuron_out_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush), .emit_valid(emit_valid),
    .emit_data(emit_data), .host_ack(host_ack), .have_out(have_out), .out_valid(out_valid),
    .out_data(out_data), .occupancy(occupancy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e, f, v;
    logic [7:0] d;
    int occ;
    logic [7:0] od;
    logic hv;
    logic [7:0] dr;
  } vec_t;
  vec_t tbl[10];

  task automatic model_reset();
    q.delete();
    hist.delete();
    hist.push_back(1'b0);
    n = 0;
    mdrop = 0;
  endtask

  // Edge n sees the pin as sampled two and three edges earlier; samples before reset release do not count.
  task automatic model_edge();
    bit rise, was_full, was_empty;
    n++;
    rise = n >= 4 && hist[n-2] && !hist[n-3];
    was_full = q.size() == 4;
    was_empty = q.size() == 0;
    if (flush) q.delete();
    else if (ena) begin
      if (rise && !was_empty) void'(q.pop_front());
      if (emit_valid && !was_full) q.push_back(emit_data);
      if (emit_valid && was_full && mdrop < 255) mdrop++;
    end
    hist.push_back(host_ack);
  endtask

  task automatic check_model();
    logic [7:0] ed;
    ed = q.size() ? q[0] : 8'h00;
    vectors++;
    if (occupancy !== 3'(q.size()) || out_data !== ed || out_valid !== (q.size() != 0) ||
        have_out !== (q.size() == 4) || drop_count !== 8'(mdrop)) begin
      miscompares++;
      $display("FAIL model t=%0t: occ=%0d data=%h valid=%b have=%b drop=%0d, expected occ=%0d data=%h drop=%0d",
               $time, occupancy, out_data, out_valid, have_out, drop_count, q.size(), ed, mdrop);
    end
  endtask

  task automatic tick(input logic e, input logic f, input logic v, input logic [7:0] d, input logic a);
    ena = e; flush = f; emit_valid = v; emit_data = d; host_ack = a;
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic do_reset(input logic a);
    rst_n = 1'b0; ena = 1'b0; flush = 1'b0; emit_valid = 1'b0; emit_data = 8'h00; host_ack = a;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'hA3, 1, 8'hA3, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h91, 1, 8'h91, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h92, 2, 8'h91, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h93, 3, 8'h91, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h94, 4, 8'h91, 1'b1, 8'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h95, 4, 8'h91, 1'b1, 8'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h96, 4, 8'h91, 1'b1, 8'd1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h97, 0, 8'h00, 1'b0, 8'd1};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h98, 0, 8'h00, 1'b0, 8'd1};

    do_reset(1'b0);
    #1;
    chk("reset_occ", 8'(occupancy), 8'd0);
    chk("reset_data", out_data, 8'h00);
    chk("reset_flags", {6'd0, have_out, out_valid}, 8'd0);
    chk("reset_drop", drop_count, 8'd0);

    foreach (tbl[i]) begin
      tick(tbl[i].e, tbl[i].f, tbl[i].v, tbl[i].d, 1'b0);
      vectors++;
      if (occupancy !== 3'(tbl[i].occ) || out_data !== tbl[i].od || have_out !== tbl[i].hv ||
          drop_count !== tbl[i].dr) begin
        miscompares++;
        $display("FAIL tbl[%0d]: occ=%0d data=%h have=%b drop=%0d, expected occ=%0d data=%h have=%b drop=%0d",
                 i, occupancy, out_data, have_out, drop_count, tbl[i].occ, tbl[i].od, tbl[i].hv, tbl[i].dr);
      end
    end

    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 8'(8'h91 + i), 1'b0);
    chk("refill_full", {7'd0, have_out}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("pop_order", out_data, i < 3 ? 8'(8'h92 + i) : 8'h00);
      repeat (2) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk("drained_valid", {7'd0, out_valid}, 8'd0);

    tick(1'b1, 1'b0, 1'b1, 8'hA1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 8'hA2, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ack_edge1", out_data, 8'hA1);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ack_edge2", out_data, 8'hA1);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ack_edge3", out_data, 8'hA2);
    repeat (20) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ack_held", out_data, 8'hA2);
    repeat (2) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ack_second_edge", 8'(occupancy), 8'd0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    tick(1'b1, 1'b0, 1'b1, 8'hB0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 8'hB1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b1);
      chk("wrap_occ", 8'(occupancy), 8'd2);
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("wrap_tail", out_data, 8'hC9);

    tick(1'b1, 1'b0, 1'b1, 8'hD0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 8'hD1, 1'b0);
    chk("pre_flush_occ", 8'(occupancy), 8'd3);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 8'hD2, 1'b1);
    chk("flush_occ", 8'(occupancy), 8'd0);
    chk("flush_data", out_data, 8'h00);
    chk("flush_drop", drop_count, 8'd1);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 8'(8'hE0 + i), 1'b0);
    tick(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
    chk("flush_full_drop", drop_count, 8'd1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 8'(8'hE0 + i), 1'b0);
    repeat (300) tick(1'b1, 1'b0, 1'b1, 8'hEF, 1'b0);
    chk("drop_sat", drop_count, 8'hFF);
    tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("drop_kept_by_flush", drop_count, 8'hFF);

    tick(1'b1, 1'b0, 1'b1, 8'hF0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 8'hF1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_occ", 8'(occupancy), 8'd0);
    chk("async_data", out_data, 8'h00);
    chk("async_flags", {6'd0, have_out, out_valid}, 8'd0);
    chk("async_drop", drop_count, 8'd0);
    do_reset(1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'h8A, 1'b1);
    repeat (6) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ack_through_reset", 8'(occupancy), 8'd1);

    tick(1'b1, 1'b0, 1'b1, 8'h8B, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'h8C, 1'b0);
    chk("ena_low_no_push", 8'(occupancy), 8'd2);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (5) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ena_low_ack_lost", 8'(occupancy), 8'd2);
    chk("ena_low_head", out_data, 8'h8A);

    do_reset(1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic a;
      a = ($urandom_range(0, 2) == 0) ? ~host_ack : host_ack;
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, 1'($urandom),
           {1'b1, 7'($urandom)}, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/neuron_out_queue.md
Name: neuron_out_queue

Overview:
- Output stage directly downstream of the per-mode neuron emitters (conv, LIF, etc.).
- Captures each emitted event byte (emit_valid/emit_data) into a small FIFO.
- Presents the head byte to the host pins; the host pops it with an asynchronous acknowledge toggle.
- Drives have_out back to the emitters. Emitters never emit while have_out is high.

Parameters:
- DEPTH, 4, number of byte entries; power of two, ≥2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; push and pop are suppressed when low
- flush  input  1  synchronous clear of queue contents
- emit_valid  input  1  one-cycle event strobe from emitter
- emit_data  input  8  event byte {1'b1, type[2:0], payload[3:0]}
- host_ack  input  1  asynchronous host acknowledge level (pin); each rising edge pops one entry
- have_out  output  1  queue full (registered)
- out_valid  output  1  queue non-empty
- out_data  output  8  head entry; 8'h00 when empty
- occupancy  output  AW+1  current entry count, 0..DEPTH
- drop_count  output  8  saturating count of emit_valid strobes received while full

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count go to 0; have_out=0, out_valid=0, out_data=8'h00, occupancy=0, drop_count=0.
  - Synchronizer flops go to 0.
  - Storage array needs no reset.
  - Reset mid-operation discards all entries. A host_ack held high through reset release does not produce a pop.
- Ack synchronizer: three flops, ack_s1 ← host_ack, ack_s2 ← ack_s1, ack_s3 ← ack_s2.
  - They shift every cycle regardless of ena/flush.
  - ack_rise = ack_s2 & ~ack_s3.
  - Pop request is registered 2 cycles after host_ack is sampled high; the entry is removed on the 3rd rising clk edge.
- push = ena & emit_valid & ~full. pop = ena & ack_rise & ~empty. Qualification uses state at the current edge.
- Push writes emit_data at wr_ptr; wr_ptr increments modulo DEPTH, with natural wrap.
- Pop advances rd_ptr modulo DEPTH.
- Simultaneous push and pop (non-empty, non-full): both occur and count is unchanged.
- Empty with push and ack_rise together: push occurs, pop is ignored, count becomes 1. The ack edge is lost and not queued.
- Full with emit_valid and ack_rise together: pop occurs, the push is rejected, and drop_count increments.
- drop_count increments when ena & emit_valid & full. It saturates at 8'hFF and is cleared only by reset; flush does not clear it.
- flush (while ena is either level):
  - On the next edge, pointers and count become 0.
  - It overrides push and pop in the same cycle.
  - drop_count is not incremented on a flush cycle.
- ena low: no push, no pop, no drop counting. Contents are held. Ack edges occurring while ena is low are lost.
- have_out = (count == DEPTH). out_valid = (count != 0). Both are derived from registered count, with no combinational path from inputs.
- out_data = mem[rd_ptr] when count != 0, else 8'h00. It changes only on clock edges.
  - Because emitted bytes always have bit7=1, the host may treat out_data[7] as valid.
- occupancy = count, range 0..DEPTH in AW+1 bits.
- Type and payload fields pass through unmodified; the block does not interpret the byte.

Test Plan:
- Reset, then push 8'hA3 with one emit_valid pulse → next cycle out_valid=1, out_data=8'hA3, occupancy=1, have_out=0.
- Push 8'h91, 8'h92, 8'h93, 8'h94 → have_out=1, occupancy=4. A fifth emit_valid of 8'h95 → drop_count=1 and contents unchanged. Four ack rising edges then return 91, 92, 93, 94 in order, and afterwards out_data=8'h00, out_valid=0.
- Raise host_ack at cycle N with queue holding {A1,A2} → out_data becomes 8'hA2 exactly after the 3rd clk edge. Holding host_ack high for 20 cycles causes no further pop; a falling then rising edge pops A2.
- Pointer wrap: 10 alternating push/pop pairs, including same-cycle push+pop at occupancy=2 → occupancy stays 2 and the output sequence is in strict FIFO order.
- flush asserted together with emit_valid and ack_rise at occupancy=3 → next cycle occupancy=0, out_data=8'h00, drop_count unchanged. 300 emit_valid pulses while full → drop_count saturates at 8'hFF.
- Assert rst_n low asynchronously mid-cycle with occupancy=2 → outputs go to reset values immediately, without waiting for a clk edge. ena=0 with emit_valid → no push; ena=0 during an ack edge → no pop after ena returns high.
